// File: rtl/pc_trace_pkg.sv
// pc_trace_pkg: shared types for the retired-PC trace monitor.
//   SEQ_W         default sequence-tag width
//   trace_entry_t one buffered trace record {pc, seq}
//   trace_state_t monitor FSM states
//   sat_inc16     saturating 16-bit increment
`timescale 1ns/1ps
package pc_trace_pkg;

  localparam int unsigned SEQ_W = 16;

  typedef struct packed {
    logic [31:0]      pc;
    logic [SEQ_W-1:0] seq;
  } trace_entry_t;

  typedef enum logic [1:0] {TR_IDLE, TR_RUN, TR_HALTED} trace_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pc_trace_fifo.sv
// pc_trace_fifo: synchronous FIFO of trace_entry_t.
//   CLK     in   clock, rising edge
//   RESET   in   asynchronous active-low reset
//   clear   in   synchronous flush (wins over push/pop)
//   push    in   write request for din
//   pop     in   read request; ignored when empty
//   din     in   entry to write
//   head    out  current head entry; holds the last popped entry while empty
//   empty   out  no entries stored
//   push_ok out  push accepted this cycle (not full, or full with a pop)
`timescale 1ns/1ps
module pc_trace_fifo
  import pc_trace_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  trace_entry_t din,
  output trace_entry_t head,
  output logic         empty,
  output logic         push_ok
);

  localparam int unsigned AW = $clog2(DEPTH);

  trace_entry_t mem [DEPTH];
  trace_entry_t hold_q;
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         full;
  logic         pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      hold_q <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      hold_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
        hold_q <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

  // Storage is not reset; pointers alone define which slots are live.
  always_ff @(posedge CLK) begin
    if (push_ok && !clear) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Once drained, present the last popped entry so the outputs stay stable.
  assign head = empty ? hold_q : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/pc_trace_monitor.sv
// pc_trace_monitor: buffers the retired-PC stream with sequence tags, counts
// retires, and flags end of test when one PC retires HALT_REPEAT times in a row.
//   CLK             in   clock, rising edge
//   RESET           in   asynchronous active-low reset
//   in_pc_enable    in   retire strobe
//   in_pc           in   retired PC
//   in_clear        in   sync clear of FIFO, counters, halt and overflow
//   in_ready        in   consumer accepts the head entry
//   out_valid       out  head entry valid
//   out_pc/out_seq  out  head entry
//   out_halted      out  sticky halt flag; out_halt_pc holds the halting PC
//   out_overflow    out  sticky: a retire was dropped on a full FIFO
//   out_drop_count  out  dropped retires, saturating
//   out_retired_cnt out  retires observed while running, wrapping
// Build option: define PC_TRACE_DISPLAY_EN to print trace events in simulation.
`timescale 1ns/1ps
module pc_trace_monitor
  import pc_trace_pkg::trace_entry_t, pc_trace_pkg::trace_state_t,
         pc_trace_pkg::TR_IDLE, pc_trace_pkg::TR_RUN, pc_trace_pkg::TR_HALTED,
         pc_trace_pkg::sat_inc16;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned SEQ_W       = pc_trace_pkg::SEQ_W,
  parameter int unsigned HALT_REPEAT = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             in_pc_enable,
  input  logic [31:0]      in_pc,
  input  logic             in_clear,
  input  logic             in_ready,
  output logic             out_valid,
  output logic [31:0]      out_pc,
  output logic [SEQ_W-1:0] out_seq,
  output logic             out_halted,
  output logic [31:0]      out_halt_pc,
  output logic             out_overflow,
  output logic [15:0]      out_drop_count,
  output logic [31:0]      out_retired_cnt
);

  localparam int unsigned RPT_W = $clog2(HALT_REPEAT + 1);

  trace_state_t     state_q;
  logic [SEQ_W-1:0] seq_q;
  logic [31:0]      last_pc_q;
  logic [RPT_W-1:0] rpt_q;
  logic [RPT_W-1:0] rpt_next;
  logic             halt_hit;
  logic             capture;
  logic             pop;
  logic             push_ok;
  logic             empty;
  logic             drop;
  trace_entry_t     din;
  trace_entry_t     head;

  assign capture = in_pc_enable & ~in_clear & (state_q != TR_HALTED);
  assign pop     = out_valid & in_ready & ~in_clear;
  assign drop    = capture & ~push_ok;

  // rpt_q == 0 marks "no previous retire" so a first PC of 0 is not a repeat.
  always_comb begin
    rpt_next = RPT_W'(1);
    if (rpt_q != '0 && in_pc == last_pc_q)
      rpt_next = (rpt_q == RPT_W'(HALT_REPEAT)) ? rpt_q : rpt_q + 1'b1;
    halt_hit = (rpt_next == RPT_W'(HALT_REPEAT));
  end

  assign din.pc  = in_pc;
  assign din.seq = seq_q;

  pc_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK     (CLK),
    .RESET   (RESET),
    .clear   (in_clear),
    .push    (capture),
    .pop     (pop),
    .din     (din),
    .head    (head),
    .empty   (empty),
    .push_ok (push_ok)
  );

  assign out_valid = ~empty;
  assign out_pc    = head.pc;
  assign out_seq   = head.seq;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q         <= TR_IDLE;
      seq_q           <= '0;
      last_pc_q       <= '0;
      rpt_q           <= '0;
      out_halted      <= 1'b0;
      out_halt_pc     <= '0;
      out_overflow    <= 1'b0;
      out_drop_count  <= '0;
      out_retired_cnt <= '0;
    end else if (in_clear) begin
      state_q         <= TR_IDLE;
      seq_q           <= '0;
      last_pc_q       <= '0;
      rpt_q           <= '0;
      out_halted      <= 1'b0;
      out_halt_pc     <= '0;
      out_overflow    <= 1'b0;
      out_drop_count  <= '0;
      out_retired_cnt <= '0;
    end else if (capture) begin
      seq_q           <= seq_q + 1'b1;
      out_retired_cnt <= out_retired_cnt + 32'd1;
      last_pc_q       <= in_pc;
      rpt_q           <= rpt_next;
      if (halt_hit) begin
        state_q     <= TR_HALTED;
        out_halted  <= 1'b1;
        out_halt_pc <= in_pc;
      end else begin
        state_q <= TR_RUN;
      end
      if (drop) begin
        out_overflow   <= 1'b1;
        out_drop_count <= sat_inc16(out_drop_count);
      end
    end
  end

`ifdef PC_TRACE_DISPLAY_EN
  always_ff @(posedge CLK) begin
    if (RESET && capture) begin
      if (push_ok) $write("[Trace] seq %0d pc %h\n", seq_q, in_pc);
      else         $write("[Trace] drop %h\n", in_pc);
      if (halt_hit) $write("[Trace] halted at %h\n", in_pc);
    end
  end
`else
`endif

endmodule

// File: tb/tb_pc_trace_monitor.sv
`timescale 1ns/1ps
module tb_pc_trace_monitor;

  localparam int DEPTH = 16;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        in_pc_enable = 1'b0;
  logic [31:0] in_pc = '0;
  logic        in_clear = 1'b0;
  logic        in_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [15:0] out_seq;
  logic        out_halted;
  logic [31:0] out_halt_pc;
  logic        out_overflow;
  logic [15:0] out_drop_count;
  logic [31:0] out_retired_cnt;

  pc_trace_monitor #(.DEPTH(DEPTH), .SEQ_W(16), .HALT_REPEAT(4)) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .in_pc_enable    (in_pc_enable),
    .in_pc           (in_pc),
    .in_clear        (in_clear),
    .in_ready        (in_ready),
    .out_valid       (out_valid),
    .out_pc          (out_pc),
    .out_seq         (out_seq),
    .out_halted      (out_halted),
    .out_halt_pc     (out_halt_pc),
    .out_overflow    (out_overflow),
    .out_drop_count  (out_drop_count),
    .out_retired_cnt (out_retired_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pc;
    logic [15:0] seq;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake consumes one scoreboard entry.
  always @(negedge CLK) begin : monitor
    exp_t e;
    if (RESET === 1'b1 && out_valid === 1'b1 && in_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got seq %0d pc %h expected no entry", out_seq, out_pc);
      end else begin
        e = exp_q.pop_front();
        chk("pop_pc", {32'd0, out_pc}, {32'd0, e.pc});
        chk("pop_seq", {48'd0, out_seq}, {48'd0, e.seq});
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic retire(input logic [31:0] pc, input bit keep, input logic [15:0] seq);
    exp_t e;
    in_pc_enable = 1'b1;
    in_pc        = pc;
    if (keep) begin
      e.pc  = pc;
      e.seq = seq;
      exp_q.push_back(e);
    end
    tick();
    in_pc_enable = 1'b0;
  endtask

  task automatic clear_pulse();
    in_clear = 1'b1;
    tick();
    in_clear = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
    chk({name, "_drained"}, exp_q.size(), 0);
    chk({name, "_valid_low"}, out_valid, 0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_halted", out_halted, 0);
    chk("rst_overflow", out_overflow, 0);
    chk("rst_drop", out_drop_count, 0);
    chk("rst_retired", out_retired_cnt, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_seq", out_seq, 0);
    RESET = 1'b1;
    tick();

    // 1: three retires streamed straight through
    in_ready = 1'b1;
    retire(32'h8000_0000, 1, 0);
    retire(32'h8000_0004, 1, 1);
    retire(32'h8000_0008, 1, 2);
    wait_drain("t1");
    chk("t1_retired", out_retired_cnt, 3);
    chk("t1_halted", out_halted, 0);

    // 2: overflow with consumer stalled
    clear_pulse();
    in_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++)
      retire(32'h1000 + 32'(4 * i), i < DEPTH, 16'(i));
    chk("t2_valid", out_valid, 1);
    chk("t2_overflow", out_overflow, 1);
    chk("t2_drop", out_drop_count, 2);
    chk("t2_retired", out_retired_cnt, DEPTH + 2);
    in_ready = 1'b1;
    wait_drain("t2");
    chk("t2_hold_pc", out_pc, 32'h103C);
    chk("t2_hold_seq", out_seq, DEPTH - 1);

    // 3: self-loop halt detection
    clear_pulse();
    retire(32'h100, 1, 0);
    retire(32'h200, 1, 1);
    retire(32'h200, 1, 2);
    retire(32'h200, 1, 3);
    chk("t3_not_yet", out_halted, 0);
    retire(32'h200, 1, 4);
    chk("t3_halted", out_halted, 1);
    chk("t3_halt_pc", out_halt_pc, 32'h200);
    retire(32'h200, 0, 0);
    chk("t3_retired", out_retired_cnt, 5);
    wait_drain("t3");
    chk("t3_still_halted", out_halted, 1);

    // 4: push and pop on a full FIFO in the same cycle
    clear_pulse();
    in_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      retire(32'h2000 + 32'(4 * i), 1, 16'(i));
    in_ready = 1'b1;
    retire(32'h2000 + 32'(4 * DEPTH), 1, 16'(DEPTH));
    in_ready = 1'b0;
    chk("t4_overflow", out_overflow, 0);
    chk("t4_drop", out_drop_count, 0);
    chk("t4_retired", out_retired_cnt, DEPTH + 1);
    // Occupancy should still be DEPTH, so the next retire drops.
    retire(32'h2000 + 32'(4 * (DEPTH + 1)), 0, 0);
    chk("t4_full_drop", out_drop_count, 1);
    chk("t4_full_overflow", out_overflow, 1);
    in_ready = 1'b1;
    wait_drain("t4");

    // 5: asynchronous reset mid-stream
    clear_pulse();
    in_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      retire(32'h2800 + 32'(4 * i), 1, 16'(i));
    chk("t5_valid_before", out_valid, 1);
    RESET = 1'b0;
    #2;
    chk("t5_valid", out_valid, 0);
    chk("t5_retired", out_retired_cnt, 0);
    chk("t5_seq", out_seq, 0);
    exp_q.delete();
    tick();
    RESET = 1'b1;
    in_ready = 1'b1;
    retire(32'h3000, 1, 0);
    wait_drain("t5");

    // 6: clear out of the halted state
    retire(32'h500, 1, 1);
    retire(32'h500, 1, 2);
    retire(32'h500, 1, 3);
    retire(32'h500, 1, 4);
    chk("t6_halted", out_halted, 1);
    retire(32'h600, 0, 0);
    chk("t6_ignored", out_retired_cnt, 5);
    wait_drain("t6a");
    clear_pulse();
    chk("t6_cleared", out_halted, 0);
    chk("t6_clr_valid", out_valid, 0);
    chk("t6_clr_retired", out_retired_cnt, 0);
    chk("t6_clr_halt_pc", out_halt_pc, 0);
    retire(32'h400, 1, 0);
    chk("t6_retired", out_retired_cnt, 1);
    wait_drain("t6b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
